// File: rtl/button_conditioner_if.sv
// button_conditioner_if
// Groups the button pins and the conditioned event outputs of one
// button_conditioner instance.
//   btn_raw     : raw, asynchronous button pins (driven by the board side)
//   btn_level   : debounced level
//   btn_press   : 1-cycle pulse on each debounced 0->1 transition
//   btn_release : 1-cycle pulse on each debounced 1->0 transition
//   btn_repeat  : press pulse followed by auto-repeat pulses while held
// Modports: master = board/consumer side, slave = the conditioner itself.
interface button_conditioner_if #(
    parameter int unsigned N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner
// Per-channel two-flop synchronizer, counter-based debouncer, registered
// press/release pulses and an optional auto-repeat pulse train for held
// buttons. Channels are independent; bit order [0]=BTNC [1]=BTNU [2]=BTNL
// [3]=BTNR [4]=BTND.
// Ports:
//   CLK100MHZ  : single clock, all state changes on the rising edge
//   CPU_RESETN : asynchronous active-low reset
//   btns       : button_conditioner_if slave (btn_raw in; level, press,
//                release and repeat out)
module button_conditioner #(
    parameter int unsigned       CLK_FREQ        = 100_000_000,
    parameter int unsigned       N_BTN           = 5,
    parameter int unsigned       DEBOUNCE_MS     = 10,
    parameter int unsigned       REPEAT_DELAY_MS = 500,
    parameter int unsigned       REPEAT_RATE_MS  = 100,
    parameter logic [N_BTN-1:0]  REPEAT_MASK     = 5'b00010
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESETN,
    button_conditioner_if.slave  btns
);

    localparam int unsigned DEB_CYCLES  = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned DLY_CYCLES  = CLK_FREQ / 1000 * REPEAT_DELAY_MS;
    localparam int unsigned RATE_CYCLES = CLK_FREQ / 1000 * REPEAT_RATE_MS;
    localparam int unsigned MAX_REP     = (DLY_CYCLES > RATE_CYCLES) ? DLY_CYCLES : RATE_CYCLES;
    localparam int unsigned DEB_W       = $clog2(DEB_CYCLES + 1);
    localparam int unsigned REP_W       = $clog2(MAX_REP + 1);

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(DLY_CYCLES - 1);
    localparam logic [REP_W-1:0] RATE_LAST = REP_W'(RATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] rep;
    // Debounced edges, valid in the cycle before level changes; they feed
    // the press/release registers and the repeat FSMs so all three move on
    // the same clock edge.
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btns.btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_deb
        logic [DEB_W-1:0] deb_cnt;
        logic             deb_done;

        assign deb_done = (sync2[i] != level[i]) && (deb_cnt == DEB_LAST);
        assign rise[i]  = deb_done &  sync2[i];
        assign fall[i]  = deb_done & ~sync2[i];

        always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
                deb_cnt <= '0;
            end else if (sync2[i] == level[i] || deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            level <= '0;
            press <= '0;
            rel   <= '0;
        end else begin
            level <= level ^ (rise | fall);
            press <= rise;
            rel   <= fall;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_rep
        if (REPEAT_MASK[i]) begin : g_on
            rep_state_t       state;
            rep_state_t       state_next;
            logic [REP_W-1:0] rep_cnt;
            logic [REP_W-1:0] cnt_next;
            logic             pulse;
            logic             pulse_next;

            always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
                if (!CPU_RESETN) begin
                    state   <= IDLE;
                    rep_cnt <= '0;
                    pulse   <= 1'b0;
                end else begin
                    state   <= state_next;
                    rep_cnt <= cnt_next;
                    pulse   <= pulse_next;
                end
            end

            // A debounced fall wins over a repeat pulse due in the same cycle.
            always_comb begin
                state_next = state;
                cnt_next   = rep_cnt;
                pulse_next = 1'b0;
                unique case (state)
                    IDLE: begin
                        if (rise[i]) begin
                            pulse_next = 1'b1;
                            cnt_next   = '0;
                            state_next = DELAY;
                        end
                    end
                    DELAY: begin
                        if (fall[i]) begin
                            cnt_next   = '0;
                            state_next = IDLE;
                        end else if (rep_cnt == DLY_LAST) begin
                            pulse_next = 1'b1;
                            cnt_next   = '0;
                            state_next = REPEAT;
                        end else begin
                            cnt_next = rep_cnt + REP_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (fall[i]) begin
                            cnt_next   = '0;
                            state_next = IDLE;
                        end else if (rep_cnt == RATE_LAST) begin
                            pulse_next = 1'b1;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = rep_cnt + REP_W'(1);
                        end
                    end
                    default: begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                endcase
            end

            assign rep[i] = pulse;
        end else begin : g_off
            assign rep[i] = 1'b0;
        end
    end

    assign btns.btn_level   = level;
    assign btns.btn_press   = press;
    assign btns.btn_release = rel;
    assign btns.btn_repeat  = rep;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
// Directed scenarios with hand-computed expectations followed by randomized
// button activity. A history-window model (a level flips when the last
// DEB_CYCLES synchronized samples all disagree with it; repeats fall at
// fixed offsets from the press edge) is compared against every output on
// every falling clock edge.
module tb_button_conditioner;

    localparam int unsigned N    = 5;
    localparam int          DEB  = 4;
    localparam int          DLY  = 10;
    localparam int          RATE = 3;
    localparam logic [N-1:0] MASK = 5'b00010;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    button_conditioner_if #(.N_BTN(N)) bif ();

    button_conditioner #(
        .CLK_FREQ        (1000),
        .N_BTN           (N),
        .DEBOUNCE_MS     (4),
        .REPEAT_DELAY_MS (10),
        .REPEAT_RATE_MS  (3),
        .REPEAT_MASK     (MASK)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .btns       (bif.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] hist[$];     // raw value sampled at each edge since reset
    logic [N-1:0] m_level = '0;
    int           press_edge[N];

    function automatic logic [N-1:0] raw_at(input int idx);
        if (idx < 0) return '0;
        return hist[idx];
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] e_press, e_rel, e_rep, new_lvl, smp;
        int           k, d;
        bit           flip;
        if (!rst_n) begin
            hist.delete();
            m_level = '0;
            check("rst_level",   bif.btn_level,   '0);
            check("rst_press",   bif.btn_press,   '0);
            check("rst_release", bif.btn_release, '0);
            check("rst_repeat",  bif.btn_repeat,  '0);
        end else begin
            hist.push_back(bif.btn_raw);
            k = hist.size() - 1;
            for (int i = 0; i < N; i++) begin
                flip = 1'b1;
                // sync2 seen at edge m is the raw value sampled at edge m-1
                for (int j = 1; j <= DEB; j++) begin
                    smp = raw_at(k - 1 - j);
                    if (smp[i] == m_level[i]) flip = 1'b0;
                end
                new_lvl[i] = m_level[i] ^ flip;
                e_press[i] = flip &  new_lvl[i];
                e_rel[i]   = flip & ~new_lvl[i];
                if (e_press[i]) press_edge[i] = k;
                d = k - press_edge[i];
                e_rep[i] = MASK[i] && new_lvl[i] &&
                           (d == 0 || (d >= DLY && (d - DLY) % RATE == 0));
            end
            m_level = new_lvl;
            check("model_level",   bif.btn_level,   new_lvl);
            check("model_press",   bif.btn_press,   e_press);
            check("model_release", bif.btn_release, e_rel);
            check("model_repeat",  bif.btn_repeat,  e_rep);
        end
    end

    // ---------------- stimulus ----------------
    // Returns just after a falling edge; the rising edge before it has
    // already been processed and inputs set now are sampled at the next one.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic   seen;
        int     hold[N];

        bif.btn_raw = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_level_lit",  bif.btn_level,  '0);
        check("reset_repeat_lit", bif.btn_repeat, '0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Clean press on BTNC: raw high from edge 0
        bif.btn_raw[0] = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e == 4) check("btnc_press_e4", bif.btn_press, 5'b00000);
            if (e == 5) begin
                check("btnc_press_e5", bif.btn_press, 5'b00001);
                check("btnc_level_e5", bif.btn_level, 5'b00001);
                check("btnc_repeat_e5", bif.btn_repeat, 5'b00000);
            end
            if (e == 6) check("btnc_press_e6", bif.btn_press, 5'b00000);
        end
        bif.btn_raw[0] = 1'b0;
        repeat (10) tick();

        // Glitch on BTNR: 3 high samples must not propagate
        bif.btn_raw[3] = 1'b1;
        repeat (3) tick();
        bif.btn_raw[3] = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | bif.btn_press[3] | bif.btn_level[3] | bif.btn_release[3];
        end
        check("glitch3_any", {31'b0, seen}, 32'd0);

        // 4 high samples are enough
        bif.btn_raw[3] = 1'b1;
        repeat (4) tick();
        bif.btn_raw[3] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | bif.btn_press[3];
        end
        check("glitch4_press", {31'b0, seen}, 32'd1);
        repeat (12) tick();

        // Hold BTNU, then reset during REPEAT
        bif.btn_raw[1] = 1'b1;
        for (int e = 0; e <= 5; e++) tick();
        check("btnu_press_P",  bif.btn_press,  5'b00010);
        check("btnu_repeat_P", bif.btn_repeat, 5'b00010);
        for (int d = 1; d <= 15; d++) begin
            tick();
            if (d == 9)  check("btnu_rep_P9",  bif.btn_repeat, 5'b00000);
            if (d == 10) check("btnu_rep_P10", bif.btn_repeat, 5'b00010);
            if (d == 12) check("btnu_rep_P12", bif.btn_repeat, 5'b00000);
            if (d == 13) check("btnu_rep_P13", bif.btn_repeat, 5'b00010);
        end
        rst_n = 1'b0;
        #1;
        check("async_rst_level",   bif.btn_level,   '0);
        check("async_rst_press",   bif.btn_press,   '0);
        check("async_rst_release", bif.btn_release, '0);
        check("async_rst_repeat",  bif.btn_repeat,  '0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            if (e == 4) check("rearm_press_e4", bif.btn_press, 5'b00000);
        end
        check("rearm_press",  bif.btn_press,  5'b00010);
        check("rearm_repeat", bif.btn_repeat, 5'b00010);
        for (int d = 1; d <= 10; d++) begin
            tick();
            if (d == 3)  check("rearm_rep_d3",  bif.btn_repeat, 5'b00000);
            if (d == 10) check("rearm_rep_d10", bif.btn_repeat, 5'b00010);
        end
        bif.btn_raw[1] = 1'b0;
        repeat (12) tick();

        // Simultaneous BTNL + BTND
        bif.btn_raw = 5'b10100;
        for (int e = 0; e <= 5; e++) tick();
        check("simul_press", bif.btn_press, 5'b10100);
        check("simul_level", bif.btn_level, 5'b10100);
        bif.btn_raw = '0;
        repeat (12) tick();

        // Randomized activity on all channels, with two reset pulses
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 12);
        for (int c = 0; c < 3000; c++) begin
            if (c == 1000 || c == 2000) begin
                rst_n = 1'b0;
                #1;
                check("rand_async_rst", {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat}, '0);
                tick();
                tick();
                rst_n = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    bif.btn_raw[i] = ~bif.btn_raw[i];
                    if ($urandom_range(0, 5) == 0) hold[i] = $urandom_range(15, 40);
                    else hold[i] = $urandom_range(1, 10);
                end
            end
            tick();
        end

        bif.btn_raw = '0;
        repeat (12) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage that sits between the board push-buttons (BTNC, BTNU, BTNL, BTNR, BTND) and the clock-control logic. Each channel gets a two-flop synchronizer, a counter-based debouncer, registered press and release pulses, and an optional auto-repeat pulse train for held buttons. The mode, select and increment logic consume clean, single-cycle events in place of raw pins. BTNU uses auto-repeat so a held button keeps incrementing the selected field.

## Interface
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- N_BTN, 5: channel count. Bit order is [0]=BTNC, [1]=BTNU, [2]=BTNL, [3]=BTNR, [4]=BTND.
- DEBOUNCE_MS, 10: stability window. DEB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS (must be ≥1).
- REPEAT_DELAY_MS, 500: hold time before the first auto-repeat. DLY_CYCLES = CLK_FREQ/1000*REPEAT_DELAY_MS.
- REPEAT_RATE_MS, 100: auto-repeat period. RATE_CYCLES = CLK_FREQ/1000*REPEAT_RATE_MS.
- REPEAT_MASK, 5'b00010: channels with auto-repeat enabled.
- CLK100MHZ  in  1  the single clock. All state changes on its rising edge.
- CPU_RESETN  in  1  reset, asynchronous, active-low.
- btn_raw  in  N_BTN  raw, asynchronous button pins.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  1-cycle pulse on each debounced 0→1 transition.
- btn_release  out  N_BTN  1-cycle pulse on each debounced 1→0 transition.
- btn_repeat  out  N_BTN  1-cycle pulse on press, then auto-repeat pulses while held. This output is tied to 0 on channels not set in REPEAT_MASK.

## Operation
- Channels are fully independent. Simultaneous activity on several channels is processed in parallel with no priority.
- Synchronizer: sync1 <= btn_raw; sync2 <= sync1.
- Debouncer, per channel, with counter deb_cnt of width $clog2(DEB_CYCLES+1):
  - If sync2 == btn_level: deb_cnt <= 0.
  - Else, if deb_cnt == DEB_CYCLES-1: btn_level <= sync2 and deb_cnt <= 0.
  - Else: deb_cnt <= deb_cnt+1.
  - Any single cycle of agreement restarts the window, so glitches shorter than DEB_CYCLES never propagate.
- btn_press and btn_release are registered and asserted on the same edge that btn_level changes. They are 0 in every other cycle.
- Repeat FSM, per masked channel, with states IDLE, DELAY, REPEAT:
  - IDLE: on a debounced rise, pulse btn_repeat, load rep_cnt <= 0, go to DELAY.
  - DELAY: rep_cnt increments each cycle. When rep_cnt == DLY_CYCLES-1, pulse btn_repeat, set rep_cnt <= 0, go to REPEAT.
  - REPEAT: rep_cnt increments each cycle. When rep_cnt == RATE_CYCLES-1, pulse btn_repeat and set rep_cnt <= 0.
  - DELAY or REPEAT: a debounced fall forces IDLE immediately and clears rep_cnt. No pulse is emitted in that cycle, and it takes priority over a pending repeat pulse.
- rep_cnt width is $clog2(max(DLY_CYCLES, RATE_CYCLES)+1). Counters never wrap, because they are cleared at the terminal count.
- Reset (CPU_RESETN low, asynchronous) clears all of the following: sync1, sync2, btn_level, btn_press, btn_release, btn_repeat, deb_cnt, rep_cnt, and FSM state (to IDLE).
  - A button held across reset release is treated as a fresh press, visible after the normal debounce latency.
  - Reset asserted mid-pulse or mid-repeat aborts the pulse or repeat with no residual pulse.

## Timing
- Press latency: let the first rising edge at which btn_raw is sampled high be edge 0. sync2 is high after edge 1. btn_level and btn_press assert after edge DEB_CYCLES+1.
- Release latency is identical.
- btn_press, btn_release and btn_repeat are exactly 1 cycle wide.
- Minimum spacing between a press and the following release is DEB_CYCLES cycles.
- First repeat: the initial repeat pulse coincides with btn_press. The second comes DLY_CYCLES cycles after btn_press, and later ones every RATE_CYCLES cycles.
- No combinational path from btn_raw to any output.

## Test plan
All scenarios use CLK_FREQ=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3 (so DEB_CYCLES=4, DLY_CYCLES=10, RATE_CYCLES=3).
- Clean press on BTNC, raw high from edge 0 → btn_level[0] and btn_press[0] high after edge 5. btn_press[0] low after edge 6. btn_repeat[0] stays 0.
- Glitch: raw[3] high for 3 edges, then low → btn_level[3], btn_press[3] and btn_release[3] never assert. Repeat the glitch with 4 high edges → press is asserted.
- Hold BTNU for 30 cycles past the press edge P → btn_repeat[1] pulses at P, P+10, P+13, P+16 … P+28. Releasing the raw pin at P+30 gives btn_release[1] at P+36 and no further repeat pulses.
- Simultaneous press of BTNL and BTND on the same edge → btn_press[2] and btn_press[4] assert in the same cycle. Other channels stay 0.
- Reset pulse during the REPEAT state of BTNU, raw still high → all outputs 0 immediately (asynchronous). After release, btn_press[1] and btn_repeat[1] re-assert 6 edges later, followed by a fresh 10-cycle delay.
